smi_rx_burst_scheduler: RTL

//   Drains the 0.9 GHz and 2.4 GHz RX sample FIFOs into the SMI read port.

---
 rtl/smi_rx_burst_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/smi_rx_burst_scheduler.sv
// Drains the 0.9 GHz and 2.4 GHz RX sample FIFOs into the SMI read port.
// Bursts of BURST_WORDS words per channel; each 32-bit word is sent MSB byte first, one byte per SMI strobe.
//
// state | meaning
// IDLE  | disabled or mode off, output parked at IDLE_BYTE
// ARB   | choose a channel (mode sampled here only)
// PULL  | one-cycle pull strobe to the granted FIFO
// LOAD  | capture the FIFO word, present its top byte
// SEND  | advance one byte per SMI strobe, then re-pull or re-arbitrate
module smi_rx_burst_scheduler #(
    parameter int         BURST_WORDS = 16,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [1:0]  i_mode,
    output logic        o_fifo_09_pull,
    input  logic [31:0] i_fifo_09_data,
    input  logic        i_fifo_09_empty,
    output logic        o_fifo_24_pull,
    input  logic [31:0] i_fifo_24_data,
    input  logic        i_fifo_24_empty,
    input  logic        i_smi_soe_se,
    output logic [7:0]  o_smi_data_out,
    output logic        o_smi_read_req,
    output logic        o_channel,
    output logic        o_underrun
);

    localparam int             CW        = $clog2(BURST_WORDS + 1);
    localparam logic [CW-1:0]  BURST_MAX = CW'(BURST_WORDS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_PULL = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;

    logic [2:0]    state;
    logic          soe_s1;
    logic          soe_s2;
    logic          soe_d;
    logic          strb;
    logic [31:0]   shift_q;
    logic [7:0]    data_q;
    logic [1:0]    byte_idx;
    logic [CW-1:0] burst_cnt;
    logic          chan_q;
    logic          last_grant;
    logic          underrun_q;
    logic          read_req_q;

    logic          elig_09;
    logic          elig_24;
    logic          grant_valid;
    logic          grant_ch;
    logic          gnt_empty;
    logic [CW-1:0] burst_next;
    logic          keep_burst;
    logic          busy;
    logic          any_ready;
    logic [31:0]   fifo_word;

    always_comb begin
        elig_09     = i_mode[0] & ~i_fifo_09_empty;
        elig_24     = i_mode[1] & ~i_fifo_24_empty;
        grant_valid = elig_09 | elig_24;
        // Both eligible: prefer the channel not granted last time.
        grant_ch    = (elig_09 && elig_24) ? ~last_grant : elig_24;
        gnt_empty   = chan_q ? i_fifo_24_empty : i_fifo_09_empty;
        burst_next  = burst_cnt + CW'(1);
        keep_burst  = (burst_next < BURST_MAX) && !gnt_empty;
        busy        = (state == ST_PULL) || (state == ST_LOAD) || (state == ST_SEND);
        any_ready   = elig_09 | elig_24;
        fifo_word   = chan_q ? i_fifo_24_data : i_fifo_09_data;
    end

    assign o_fifo_09_pull = (state == ST_PULL) && !chan_q && !i_fifo_09_empty;
    assign o_fifo_24_pull = (state == ST_PULL) &&  chan_q && !i_fifo_24_empty;
    assign o_smi_data_out = data_q;
    assign o_smi_read_req = read_req_q;
    assign o_channel      = chan_q;
    assign o_underrun     = underrun_q;

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            soe_s1     <= 1'b1;
            soe_s2     <= 1'b1;
            soe_d      <= 1'b1;
            strb       <= 1'b0;
            shift_q    <= 32'h0;
            data_q     <= IDLE_BYTE;
            byte_idx   <= 2'd0;
            burst_cnt  <= '0;
            chan_q     <= 1'b0;
            last_grant <= 1'b1;
            underrun_q <= 1'b0;
            read_req_q <= 1'b0;
        end else begin
            // Strobe is released on the rising edge of the active-low pad.
            soe_s1     <= i_smi_soe_se;
            soe_s2     <= soe_s1;
            soe_d      <= soe_s2;
            strb       <= soe_s2 & ~soe_d;
            read_req_q <= i_enable & (busy | any_ready);

            if (strb && (state != ST_SEND)) begin
                underrun_q <= 1'b1;
            end

            if (!i_enable) begin
                state     <= ST_IDLE;
                data_q    <= IDLE_BYTE;
                burst_cnt <= '0;
                byte_idx  <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_mode != 2'b00) begin
                            state <= ST_ARB;
                        end
                    end
                    ST_ARB: begin
                        if (grant_valid) begin
                            burst_cnt <= '0;
                            chan_q    <= grant_ch;
                            state     <= ST_PULL;
                        end
                    end
                    ST_PULL: begin
                        if (gnt_empty) begin
                            state      <= ST_ARB;
                            last_grant <= chan_q;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        shift_q  <= fifo_word;
                        data_q   <= fifo_word[31:24];
                        byte_idx <= 2'd0;
                        state    <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (strb) begin
                            if (byte_idx != 2'd3) begin
                                data_q   <= shift_q[23:16];
                                shift_q  <= {shift_q[23:0], 8'h00};
                                byte_idx <= byte_idx + 2'd1;
                            end else begin
                                burst_cnt <= burst_next;
                                if (keep_burst) begin
                                    state <= ST_PULL;
                                end else begin
                                    state      <= ST_ARB;
                                    last_grant <= chan_q;
                                end
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
